// File: rtl/distributor_pkg.sv
// Shared definitions for the two-output stream distributor.
//   SEL_Y0 / SEL_Y1 : values of the destination select s
//   slot_state_t    : occupancy of a one-entry output slot
package distributor_pkg;

  localparam logic SEL_Y0 = 1'b0;
  localparam logic SEL_Y1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/output_slot.sv
// One-entry registered output slot with valid/ready handshake and a
// delivered-word counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : write data_in into the slot this cycle (caller guarantees room)
//   data_in    : word to load
//   data       : held word (retains last value while empty)
//   valid      : slot is full
//   ready      : consumer accepts data this cycle
//   cnt        : number of completed output handshakes, wrapping
module output_slot
  import distributor_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data,
  output logic                 valid,
  input  logic                 ready,
  output logic [CNT_WIDTH-1:0] cnt
);

  slot_state_t          state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load wins over a drain so a same-cycle drain/load keeps the slot full.
  always_comb begin
    drain   = (state_q == FULL) && ready;
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, drain};
    if (load) begin
      state_d = FULL;
      data_d  = data_in;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    valid = (state_q == FULL);
    data  = data_q;
    cnt   = cnt_q;
  end

endmodule

// File: rtl/distributor2_stream.sv
// Two-output stream demultiplexer: the input stream is steered to y0 or y1
// by s, each output buffered in a one-entry slot with its own backpressure.
//   clk, reset       : clock, synchronous active-high reset
//   d, s, d_valid    : input word, destination select, input valid
//   d_ready          : input accepted this cycle (depends only on slot s)
//   y0/y1, *_valid   : output words and valids
//   y0_ready/y1_ready: consumer readies
//   cnt0/cnt1        : delivered-word counters per output, wrapping
module distributor2_stream
  import distributor_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     d,
  input  logic                 s,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic [WIDTH-1:0]     y0,
  output logic                 y0_valid,
  input  logic                 y0_ready,
  output logic [WIDTH-1:0]     y1,
  output logic                 y1_valid,
  input  logic                 y1_ready,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  logic load0, load1;

  // Only the addressed slot gates acceptance, so a stalled slot never
  // blocks traffic headed for the other one.
  always_comb begin
    if (s == SEL_Y1) begin
      d_ready = !y1_valid || y1_ready;
    end else begin
      d_ready = !y0_valid || y0_ready;
    end
    load0 = d_valid && d_ready && (s == SEL_Y0);
    load1 = d_valid && d_ready && (s == SEL_Y1);
  end

  output_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .load    (load0),
    .data_in (d),
    .data    (y0),
    .valid   (y0_valid),
    .ready   (y0_ready),
    .cnt     (cnt0)
  );

  output_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .load    (load1),
    .data_in (d),
    .data    (y1),
    .valid   (y1_valid),
    .ready   (y1_ready),
    .cnt     (cnt1)
  );

endmodule

// File: tb/tb_distributor2_stream.sv
// Self-checking bench for distributor2_stream. A second instance with 2-bit
// counters shares the inputs and checks counter wrap.
module tb_distributor2_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d = '0;
  logic       s = 1'b0;
  logic       d_valid = 1'b0;
  logic       y0_ready = 1'b0;
  logic       y1_ready = 1'b0;

  logic       d_ready, y0_valid, y1_valid;
  logic [3:0] y0, y1;
  logic [7:0] cnt0, cnt1;

  logic       w_d_ready, w_y0_valid, w_y1_valid;
  logic [3:0] w_y0, w_y1;
  logic [1:0] w_cnt0, w_cnt1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each output is a queue of at most one word.
  logic [3:0] m_q0[$];
  logic [3:0] m_q1[$];
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  always #5 clk = ~clk;

  distributor2_stream #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .s        (s),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .y0       (y0),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  distributor2_stream #(.WIDTH(4), .CNT_WIDTH(2)) dut_w (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .s        (s),
    .d_valid  (d_valid),
    .d_ready  (w_d_ready),
    .y0       (w_y0),
    .y0_valid (w_y0_valid),
    .y0_ready (y0_ready),
    .y1       (w_y1),
    .y1_valid (w_y1_valid),
    .y1_ready (y1_ready),
    .cnt0     (w_cnt0),
    .cnt1     (w_cnt1)
  );

  function automatic logic exp_ready();
    if (s) return (m_q1.size() == 0) || y1_ready;
    return (m_q0.size() == 0) || y0_ready;
  endfunction

  task automatic model_step();
    logic       acc;
    logic [3:0] tmp;
    acc = d_valid && exp_ready();
    if (reset) begin
      m_q0.delete();
      m_q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (m_q0.size() != 0 && y0_ready) begin tmp = m_q0.pop_front(); m_cnt0++; end
      if (m_q1.size() != 0 && y1_ready) begin tmp = m_q1.pop_front(); m_cnt1++; end
      if (acc) begin
        if (s) m_q1.push_back(d);
        else   m_q0.push_back(d);
      end
    end
  endtask

  task automatic set_in(input logic r, input logic [3:0] dd, input logic ss, input logic dv,
                        input logic r0, input logic r1);
    @(negedge clk);
    reset = r; d = dd; s = ss; d_valid = dv; y0_ready = r0; y1_ready = r1;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    set_in(1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1);
    advance();
    set_in(1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1);
    advance();
    vectors++;
    if ({y0_valid, y1_valid, cnt0, cnt1} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_state: got v0=%b v1=%b c0=%0d c1=%0d, want all 0",
               y0_valid, y1_valid, cnt0, cnt1);
    end
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (d_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_d_ready: got %b want 1", d_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_in(1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1);
    advance();
    vectors++;
    if ({y0, y0_valid, y1_valid} !== {4'h3, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_load: got y0=%h v0=%b v1=%b want y0=3 v0=1 v1=0",
               y0, y0_valid, y1_valid);
    end
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    advance();
    vectors++;
    if ({y0_valid, cnt0} !== {1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL single_drain: got v0=%b c0=%0d want v0=0 c0=1", y0_valid, cnt0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
    advance();
    set_in(1'b0, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (d_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_d_ready_low: got %b want 0", d_ready);
    end
    advance();
    vectors++;
    if ({y1, y1_valid} !== {4'hA, 1'b1}) begin
      miscompares++;
      $display("FAIL bp_hold: got y1=%h v1=%b want y1=a v1=1", y1, y1_valid);
    end
    set_in(1'b0, 4'hB, 1'b1, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (d_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_d_ready_high: got %b want 1", d_ready);
    end
    advance();
    vectors++;
    if ({y1, y1_valid, cnt1} !== {4'hB, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL bp_drain_load: got y1=%h v1=%b c1=%0d want y1=b v1=1 c1=1",
               y1, y1_valid, cnt1);
    end
  endtask

  task automatic test_independence();
    do_reset();
    set_in(1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0);
    advance();
    set_in(1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (d_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL indep_d_ready: got %b want 1", d_ready);
    end
    advance();
    vectors++;
    if ({y0, y0_valid, y1, y1_valid} !== {4'h5, 1'b1, 4'hA, 1'b1}) begin
      miscompares++;
      $display("FAIL indep_outputs: got y0=%h v0=%b y1=%h v1=%b want 5 1 a 1",
               y0, y0_valid, y1, y1_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 4'(i), 1'(i % 2), 1'b1, 1'b1, 1'b1);
      vectors++;
      if (d_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_d_ready[%0d]: got %b want 1", i, d_ready);
      end
      advance();
      vectors++;
      if ((i % 2 == 0) ? ({y0, y0_valid} !== {4'(i), 1'b1})
                       : ({y1, y1_valid} !== {4'(i), 1'b1})) begin
        miscompares++;
        $display("FAIL stream_word[%0d]: got y0=%h v0=%b y1=%h v1=%b want word %0d",
                 i, y0, y0_valid, y1, y1_valid, i);
      end
    end
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    advance();
    vectors++;
    if ({cnt0, cnt1} !== {8'd4, 8'd4}) begin
      miscompares++;
      $display("FAIL stream_counts: got c0=%0d c1=%0d want 4 4", cnt0, cnt1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 4'(i), 1'b0, 1'b1, 1'b1, 1'b1);
      advance();
    end
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    advance();
    vectors++;
    if ({w_cnt0, cnt0} !== {2'd1, 8'd5}) begin
      miscompares++;
      $display("FAIL wrap_count: got c0(2b)=%0d c0(8b)=%0d want 1 5", w_cnt0, cnt0);
    end
    set_in(1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
    advance();
    // Reset with a handshake pending on y0 and a load offered: neither may happen.
    set_in(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1);
    advance();
    vectors++;
    if ({w_y0_valid, w_cnt0, y0_valid, cnt0} !== {1'b0, 2'd0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL wrap_reset: got v0=%b c0(2b)=%0d v0=%b c0=%0d want all 0",
               w_y0_valid, w_cnt0, y0_valid, cnt0);
    end
  endtask

  task automatic test_random();
    logic r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      set_in(r, 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      vectors++;
      if (d_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL rand_d_ready[%0d]: got %b want %b", i, d_ready, exp_ready());
      end
      advance();
      vectors++;
      if ({y0_valid, y1_valid, cnt0, cnt1, w_cnt0, w_cnt1} !==
          {m_q0.size() != 0, m_q1.size() != 0, 8'(m_cnt0), 8'(m_cnt1),
           2'(m_cnt0), 2'(m_cnt1)}) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got v0=%b v1=%b c0=%0d c1=%0d w0=%0d w1=%0d want %b %b %0d %0d",
                 i, y0_valid, y1_valid, cnt0, cnt1, w_cnt0, w_cnt1,
                 m_q0.size() != 0, m_q1.size() != 0, m_cnt0 % 256, m_cnt1 % 256);
      end
      if (m_q0.size() != 0) begin
        vectors++;
        if (y0 !== m_q0[0]) begin
          miscompares++;
          $display("FAIL rand_y0[%0d]: got %h want %h", i, y0, m_q0[0]);
        end
      end
      if (m_q1.size() != 0) begin
        vectors++;
        if (y1 !== m_q1[0]) begin
          miscompares++;
          $display("FAIL rand_y1[%0d]: got %h want %h", i, y1, m_q1[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/distributor2_stream.md
Name: distributor2_stream

Overview:
Two-output stream demultiplexer. It is the inverse of the 2-input selector: one input stream is steered to output 0 or output 1 by select s. Each output has a one-entry registered slot with valid/ready handshake and a delivered-word counter. It sits upstream of consumers that must receive a split data stream with independent backpressure.

Parameters:
WIDTH, 4, data width of d, y0, y1
CNT_WIDTH, 8, width of per-output delivered-word counters cnt0, cnt1

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
d  input  WIDTH  input data word
s  input  1  destination select (0 -> y0, 1 -> y1); meaningful only while d_valid=1
d_valid  input  1  input word present
d_ready  output  1  block accepts input word this cycle
y0  output  WIDTH  output 0 data
y0_valid  output  1  y0 holds a word
y0_ready  input  1  consumer 0 accepts y0 this cycle
y1  output  WIDTH  output 1 data
y1_valid  output  1  y1 holds a word
y1_ready  input  1  consumer 1 accepts y1 this cycle
cnt0  output  CNT_WIDTH  words delivered on y0 (handshakes), modulo 2^CNT_WIDTH
cnt1  output  CNT_WIDTH  words delivered on y1, modulo 2^CNT_WIDTH

Behaviour:
- Reset (synchronous, active-high, wins over all other events): y0=y1='0, y0_valid=y1_valid=0, cnt0=cnt1=0. Reset mid-operation discards held words; no handshake counted in the reset cycle.
- Slot k states: EMPTY (yk_valid=0) / FULL (yk_valid=1). No other states.
- d_ready is combinational: d_ready = !ys_valid || ys_ready, where ys is the slot addressed by s. It does not depend on d_valid. It may depend on the other slot's state only through s.
- Input transfer: d_valid && d_ready at an edge loads d into slot s. Slot s becomes FULL in the next cycle. Latency is 1 cycle, input to output.
- Output transfer: yk_valid && yk_ready at an edge empties slot k and increments cntk by 1. cntk wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- Simultaneous drain and load of the same slot: the new word replaces the old one, the slot stays FULL, and cntk increments. This sustains 1 word/cycle per output.
- Simultaneous drain of one slot and load of the other slot: both take effect independently.
- Stability: while yk_valid=1 and yk_ready=0, yk and yk_valid hold unchanged.
- A stalled slot does not block traffic to the other slot.
- No word is ever duplicated or dropped, reset excepted.
- yk is don't-care while yk_valid=0, but the implementation retains the last value. There is no combinational path from d to yk.

Decomposition:
- Shared package distributor_pkg: localparam SEL_Y0=1'b0, SEL_Y1=1'b1; typedef enum logic {EMPTY, FULL} slot_state_t.
- One sub-module: output_slot#(WIDTH, CNT_WIDTH). It holds the one-entry register, the valid flag, the load/drain logic and the counter. It exposes load, data_in, data/valid/ready and cnt.
- The top level instantiates output_slot twice and derives d_ready and the per-slot load signals from s.

Test Plan:
1. Reset: assert reset 2 cycles with d_valid=1 -> y0_valid=y1_valid=0, cnt0=cnt1=0, no load. After release with y0 empty -> d_ready=1.
2. Single word: d=4'h3, s=0, d_valid=1 for 1 cycle, y0_ready=1 -> next cycle y0=4'h3, y0_valid=1, y1_valid=0. The following cycle y0_valid=0 and cnt0=1.
3. Backpressure on y1, same-cycle drain/load:
   - Hold y1_ready=0 and send 4'hA on s=1 -> y1=4'hA is held.
   - Present 4'hB on s=1 -> d_ready=0 while y1_ready=0.
   - Raise y1_ready -> A is accepted and B loads in the same cycle; next cycle y1=4'hB, cnt1=1.
4. Independence: y1 full and stalled, send 4'h5 on s=0 -> d_ready=1, next cycle y0=4'h5, y1 still 4'hA.
5. Streaming: 8 back-to-back words 0..7 with s toggling 0,1,... and both readies=1 -> y0 carries 0,2,4,6 and y1 carries 1,3,5,7, one per cycle, no stalls. Afterwards cnt0=cnt1=4.
6. Wrap: CNT_WIDTH=2, deliver 5 words to y0 -> cnt0=1. Then assert reset while y0 is full -> y0_valid=0, cnt0=0 next cycle.
